// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the parameterised synchronous FIFO.
package sync_fifo_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH_LOG2 = 4;
   // Pointers and level carry one bit above the RAM address (wrap bit / full count).
   localparam int LVL_EXTRA_BITS = 1;

   typedef struct packed {
      logic ovf;
      logic unf;
   } err_flags_t;
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
module sync_fifo_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);
   (* ram_style = "block" *) logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
   end

   // Only the output register is reset; array contents are left as-is.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with level, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through operation.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_ready,
   input  logic                  read_enable,
   output logic                  read_ready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_data_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic                  err_clear,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int LW = DEPTH_LOG2 + LVL_EXTRA_BITS;
   localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

   logic [LW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
   err_flags_t            err_q, err_d;
   logic                  push, pop, ram_rd;
   logic [DATA_WIDTH-1:0] ram_dout;

   assign ram_cnt = wr_ptr_q - rd_ptr_q;
   assign push    = write_enable && write_ready;
   assign pop     = read_enable && read_ready;

`ifdef SYNC_FIFO_FWFT_EN
   localparam logic [LW-1:0] DEPTH_L = LW'(1 << DEPTH_LOG2);
   logic ovld_q, ovld_d;

   // The RAM read register doubles as the output stage; refill it whenever it drains.
   assign level           = ram_cnt + LW'(ovld_q);
   assign write_ready     = level < DEPTH_L;
   assign read_ready      = ovld_q;
   assign read_data_valid = ovld_q;
   assign ram_rd          = (ram_cnt != '0) && (!ovld_q || pop);
   assign ovld_d          = ram_rd || (ovld_q && !pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovld_q <= 1'b0;
      else          ovld_q <= ovld_d;
   end
`else
   logic rdv_q;

   assign level           = ram_cnt;
   assign write_ready     = !((wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                              (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]));
   assign read_ready      = wr_ptr_q != rd_ptr_q;
   assign read_data_valid = rdv_q;
   assign ram_rd          = pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdv_q <= 1'b0;
      else          rdv_q <= pop;
   end
`endif

   assign read_data    = ram_dout;
   assign almost_full  = level >= AF_L;
   assign almost_empty = level <= AE_L;
   assign overflow     = err_q.ovf;
   assign underflow    = err_q.unf;

   // Set beats clear when both happen in the same cycle.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + LW'(push);
      rd_ptr_d  = rd_ptr_q + LW'(ram_rd);
      err_d.ovf = (write_enable && !write_ready) || (err_q.ovf && !err_clear);
      err_d.unf = (read_enable && !read_ready) || (err_q.unf && !err_clear);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   sync_fifo_ram #(.DW(DATA_WIDTH), .AW(DEPTH_LOG2)) u_ram (
      .clk_i     (clk),
      .rst_n_i   (reset_n),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
      .wr_data_i (write_data),
      .rd_en_i   (ram_rd),
      .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
      .rd_data_o (ram_dout)
   );
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous single-clock FIFO. Generalises the fixed 8-bit byte FIFO to arbitrary data width and power-of-two depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a registered read-data-valid strobe.
- Sits between producers and consumers inside the CPU: UART RX/TX buffering, MMIO queues, load/store decoupling.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- DEPTH_LOG2, 4, log2 of capacity; DEPTH = 2**DEPTH_LOG2 entries.
- AF_THRESH, DEPTH-1, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- write_enable  in  1  push request.
- write_data  in  DATA_WIDTH  push data.
- write_ready  out  1  FIFO can accept a push this cycle.
- read_enable  in  1  pop request.
- read_ready  out  1  FIFO can supply a pop this cycle.
- read_data  out  DATA_WIDTH  popped data (registered).
- read_data_valid  out  1  read_data updated this cycle.
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- err_clear  in  1  clears overflow/underflow.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset is asynchronous and active-low, and is asserted immediately on reset_n low, including mid-operation. It clears read/write pointers, level, read_data (0), read_data_valid, overflow and underflow. RAM contents are not cleared.
- Output values after reset: write_ready=1, read_ready=0, level=0, almost_empty=1, almost_full=(AF_THRESH==0).
- Pointers are DEPTH_LOG2+1 bits wide: the low bits address the RAM and the MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
  - Empty: pointers equal.
  - Full: low bits equal and wrap bits differ.
- Accept rules:
  - A push is accepted iff write_enable && write_ready.
  - A pop is accepted iff read_enable && read_ready.
  - Ready signals are combinational from registered state only. There is no same-cycle bypass.
- Level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop when full: the pop is accepted and the push is rejected (write_ready=0). When empty: the push is accepted and the pop is rejected.
- Read latency (standard mode):
  - Pop accepted in cycle N: read_data holds the head entry and read_data_valid=1 in cycle N+1.
  - read_data holds its value until the next accepted pop.
  - read_data_valid is a single-cycle pulse per accepted pop.
- Write-to-read: data pushed in cycle N is poppable from cycle N+1.
- almost_full and almost_empty are combinational compares on the registered level.
- Error flags:
  - write_enable while !write_ready sets overflow; read_enable while !read_ready sets underflow. The rejected request causes no state change.
  - err_clear clears both flags next cycle. If a set condition and err_clear occur in the same cycle, set wins.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN enables first-word fall-through.
- Defined:
  - An output stage prefetches the head entry.
  - read_ready = output stage occupied. read_data shows the head combinationally from that register whenever read_ready=1.
  - A pop consumes the entry in the same cycle, and read_data_valid mirrors read_ready.
  - Push into an empty FIFO sets read_ready 2 cycles later.
  - level counts RAM entries plus the output stage; capacity stays DEPTH.
- Undefined: standard mode as above.

Decomposition:
- Package sync_fifo_pkg holds the default width/depth constants, a level-width helper constant and the error-flag struct typedef.
- One sub-module, sync_fifo_ram: simple dual-port RAM with synchronous read, block-RAM style attribute, one write port and one read port.

Test Plan (DATA_WIDTH=8, DEPTH_LOG2=2, AF_THRESH=3, AE_THRESH=1):
- Push 0xA1,0xB2,0xC3,0xD4 in consecutive cycles, then pop 4 -> level 1,2,3,4; write_ready=0 at level 4; almost_full from level 3; read_data 0xA1..0xD4 each one cycle after its pop, with read_data_valid pulses.
- Full FIFO, push 0xEE with simultaneous pop -> pop accepted, 0xEE dropped, level 3, overflow=1; err_clear -> overflow=0.
- Empty FIFO, read_enable=1 -> read_ready=0, level stays 0, underflow=1, read_data unchanged.
- Wrap: 10 rounds of push 3 / pop 3 -> data order preserved, level returns to 0, no error flags.
- Assert reset_n low asynchronously mid-burst at level 2 -> outputs return to reset values before the next edge; push 0x55 after release -> pops 0x55.
- SYNC_FIFO_FWFT_EN defined: push 0x77 into empty -> read_ready=1 and read_data=0x77 two cycles later; pop in that cycle -> read_ready=0 next cycle, level 0.
